// File: rtl/match_req_dispatcher_pkg.sv
// Shared widths for the match request dispatcher slice.
// ADDR_WIDTH / MATCH_LEN_WIDTH normally arrive from the shared parameters.vh;
// the fallbacks below only apply when the slice is built on its own.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef MATCH_LEN_WIDTH
`define MATCH_LEN_WIDTH 16
`endif

package match_req_dispatcher_pkg;
    localparam int unsigned ADDR_W = `ADDR_WIDTH;
    localparam int unsigned ML_W   = `MATCH_LEN_WIDTH;
endpackage

// File: rtl/match_req_dispatcher_if.sv
// Upstream and per-PE request/response channels of the dispatcher.
// slave  : dispatcher view.
// master : environment view (upstream producer/consumer and the PEs).
interface match_req_dispatcher_if #(
    parameter int unsigned NUM_PE   = 4,
    parameter int unsigned TAG_BITS = 8
);
    localparam int unsigned AW = match_req_dispatcher_pkg::ADDR_W;
    localparam int unsigned LW = match_req_dispatcher_pkg::ML_W;

    logic                         up_req_valid;
    logic                         up_req_ready;
    logic [TAG_BITS-1:0]          up_req_tag;
    logic [AW-1:0]                up_req_head_addr;
    logic [AW-1:0]                up_req_history_addr;

    logic [NUM_PE-1:0]            pe_req_valid;
    logic [NUM_PE-1:0]            pe_req_ready;
    logic [TAG_BITS-1:0]          pe_req_tag;
    logic [AW-1:0]                pe_req_head_addr;
    logic [AW-1:0]                pe_req_history_addr;

    logic [NUM_PE-1:0]            pe_resp_valid;
    logic [NUM_PE-1:0]            pe_resp_ready;
    logic [NUM_PE*TAG_BITS-1:0]   pe_resp_tag;
    logic [NUM_PE*LW-1:0]         pe_resp_match_len;

    logic                         up_resp_valid;
    logic                         up_resp_ready;
    logic [TAG_BITS-1:0]          up_resp_tag;
    logic [LW-1:0]                up_resp_match_len;

    modport slave (
        input  up_req_valid, up_req_tag, up_req_head_addr, up_req_history_addr,
        output up_req_ready,
        output pe_req_valid, pe_req_tag, pe_req_head_addr, pe_req_history_addr,
        input  pe_req_ready,
        input  pe_resp_valid, pe_resp_tag, pe_resp_match_len,
        output pe_resp_ready,
        output up_resp_valid, up_resp_tag, up_resp_match_len,
        input  up_resp_ready
    );

    modport master (
        output up_req_valid, up_req_tag, up_req_head_addr, up_req_history_addr,
        input  up_req_ready,
        input  pe_req_valid, pe_req_tag, pe_req_head_addr, pe_req_history_addr,
        output pe_req_ready,
        output pe_resp_valid, pe_resp_tag, pe_resp_match_len,
        input  pe_resp_ready,
        input  up_resp_valid, up_resp_tag, up_resp_match_len,
        output up_resp_ready
    );
endinterface

// File: rtl/match_req_dispatcher_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after i_ptr wins.
// NUM must be a power of two so the index wraps by truncation.
module rr_arbiter #(
    parameter int unsigned NUM = 4,
    localparam int unsigned IDX_W = $clog2(NUM)
) (
    input  logic [NUM-1:0]   i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [NUM-1:0]   o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);
    logic [IDX_W-1:0] w_cand;

    // Scan from the pointer upward with wrap; keep the first hit.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        for (int unsigned off = 0; off < NUM; off++) begin
            w_cand = IDX_W'(32'(i_ptr) + off);
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end
endmodule

// File: rtl/match_req_dispatcher.sv
// Spreads upstream match jobs across NUM_PE match engines and merges their
// responses into one registered upstream stream, tracking outstanding jobs.
module match_req_dispatcher
    import match_req_dispatcher_pkg::*;
#(
    parameter int unsigned NUM_PE          = 4,
    parameter int unsigned TAG_BITS        = 8,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    match_req_dispatcher_if.slave bus,
    output logic                  idle
);
    localparam int unsigned PTR_W = $clog2(NUM_PE);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [PTR_W-1:0]    r_req_ptr;
    logic [PTR_W-1:0]    r_resp_ptr;
    logic [CNT_W-1:0]    r_outstanding;
    logic                r_resp_valid;
    logic [TAG_BITS-1:0] r_resp_tag;
    logic [ML_W-1:0]     r_resp_len;

    logic [NUM_PE-1:0]   w_req_grant;
    logic [PTR_W-1:0]    w_req_idx;
    logic                w_req_any;
    logic [NUM_PE-1:0]   w_resp_grant;
    logic [PTR_W-1:0]    w_resp_idx;
    logic                w_resp_any;

    logic                w_full;
    logic                w_req_open;
    logic                w_req_hs;
    logic                w_can_load;
    logic                w_resp_hs;
    logic                w_up_hs;
    logic [TAG_BITS-1:0] w_sel_tag;
    logic [ML_W-1:0]     w_sel_len;

    rr_arbiter #(.NUM(NUM_PE)) u_req_arb (
        .i_req   (bus.pe_req_ready),
        .i_ptr   (r_req_ptr),
        .o_grant (w_req_grant),
        .o_idx   (w_req_idx),
        .o_any   (w_req_any)
    );

    rr_arbiter #(.NUM(NUM_PE)) u_resp_arb (
        .i_req   (bus.pe_resp_valid),
        .i_ptr   (r_resp_ptr),
        .o_grant (w_resp_grant),
        .o_idx   (w_resp_idx),
        .o_any   (w_resp_any)
    );

    // Request path is pure wiring; handshakes are suppressed while in reset.
    assign w_full                  = (r_outstanding == CNT_W'(MAX_OUTSTANDING));
    assign w_req_open              = rst_n & ~w_full;
    assign bus.up_req_ready        = w_req_any & w_req_open;
    assign bus.pe_req_valid        = w_req_grant & {NUM_PE{bus.up_req_valid & w_req_open}};
    assign bus.pe_req_tag          = bus.up_req_tag;
    assign bus.pe_req_head_addr    = bus.up_req_head_addr;
    assign bus.pe_req_history_addr = bus.up_req_history_addr;
    assign w_req_hs                = bus.up_req_valid & bus.up_req_ready;

    // Output register accepts a new response when empty or draining this cycle.
    assign w_can_load        = rst_n & (~r_resp_valid | bus.up_resp_ready);
    assign bus.pe_resp_ready = w_resp_grant & {NUM_PE{w_can_load}};
    assign w_resp_hs         = w_resp_any & w_can_load;
    assign w_up_hs           = r_resp_valid & bus.up_resp_ready;

    assign bus.up_resp_valid     = r_resp_valid;
    assign bus.up_resp_tag       = r_resp_tag;
    assign bus.up_resp_match_len = r_resp_len;
    assign idle                  = (r_outstanding == '0) & ~r_resp_valid;

    // Pick the winning PE's slice out of the packed response buses.
    always_comb begin
        w_sel_tag = '0;
        w_sel_len = '0;
        for (int unsigned i = 0; i < NUM_PE; i++) begin
            if (w_resp_grant[i]) begin
                w_sel_tag = bus.pe_resp_tag[i*TAG_BITS +: TAG_BITS];
                w_sel_len = bus.pe_resp_match_len[i*ML_W +: ML_W];
            end
        end
    end

    // Request pointer advances past the PE that took the request.
    always_ff @(posedge clk) begin
        if (!rst_n)        r_req_ptr <= '0;
        else if (w_req_hs) r_req_ptr <= w_req_idx + 1'b1;
    end

    // One-entry response register; capture wins over a plain drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_resp_valid <= 1'b0;
            r_resp_tag   <= '0;
            r_resp_len   <= '0;
            r_resp_ptr   <= '0;
        end else if (w_resp_hs) begin
            r_resp_valid <= 1'b1;
            r_resp_tag   <= w_sel_tag;
            r_resp_len   <= w_sel_len;
            r_resp_ptr   <= w_resp_idx + 1'b1;
        end else if (w_up_hs) begin
            r_resp_valid <= 1'b0;
        end
    end

    // Outstanding jobs: up on accept, down on upstream drain, floor at zero.
    always_ff @(posedge clk) begin
        if (!rst_n)                      r_outstanding <= '0;
        else if (w_req_hs && !w_up_hs)   r_outstanding <= r_outstanding + 1'b1;
        else if (!w_req_hs && w_up_hs &&
                 r_outstanding != '0)    r_outstanding <= r_outstanding - 1'b1;
    end

    // A drained response with nothing outstanding means a PE answered unasked.
    always_ff @(posedge clk) begin
        if (rst_n) assert (!(w_up_hs && r_outstanding == '0));
    end
endmodule

// File: tb/tb_match_req_dispatcher.sv
// Directed bench for match_req_dispatcher (NUM_PE=4, MAX_OUTSTANDING=8).
module tb_match_req_dispatcher;
    import match_req_dispatcher_pkg::*;

    logic clk;
    logic rst_n;
    logic idle;
    int   n_checks;
    int   n_pass;

    match_req_dispatcher_if #(.NUM_PE(4), .TAG_BITS(8)) bus ();

    match_req_dispatcher #(
        .NUM_PE          (4),
        .TAG_BITS        (8),
        .MAX_OUTSTANDING (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .idle  (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_resp(input int pe, input int tag, input int len);
        bus.pe_resp_tag[pe*8 +: 8]             = 8'(tag);
        bus.pe_resp_match_len[pe*ML_W +: ML_W] = ML_W'(len);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n                   = 1'b0;
        bus.up_req_valid        = 1'b0;
        bus.up_req_tag          = '0;
        bus.up_req_head_addr    = '0;
        bus.up_req_history_addr = '0;
        bus.pe_req_ready        = '0;
        bus.pe_resp_valid       = '0;
        bus.pe_resp_tag         = '0;
        bus.pe_resp_match_len   = '0;
        bus.up_resp_ready       = 1'b0;
        repeat (2) tick();

        // Reset state
        chk("rst_up_resp_valid", bus.up_resp_valid, 0);
        chk("rst_idle", idle, 1);
        chk("rst_pe_resp_ready", bus.pe_resp_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_up_req_ready_no_pe", bus.up_req_ready, 0);

        // Eight back-to-back requests rotate over all PEs, then the bench is full
        bus.pe_req_ready = 4'hF;
        bus.up_req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.up_req_tag          = 8'(i + 1);
            bus.up_req_head_addr    = ADDR_W'(i * 16);
            bus.up_req_history_addr = ADDR_W'(i * 16 + 4);
            #1;
            chk("b2b_pe_req_valid", bus.pe_req_valid, 64'(1 << (i % 4)));
            chk("b2b_up_req_ready", bus.up_req_ready, 1);
            chk("b2b_pe_req_tag", bus.pe_req_tag, 64'(i + 1));
            chk("b2b_pe_req_hist", bus.pe_req_history_addr, 64'(i * 16 + 4));
            tick();
        end
        chk("full_up_req_ready", bus.up_req_ready, 0);
        chk("full_pe_req_valid", bus.pe_req_valid, 0);
        chk("full_idle", idle, 0);
        bus.up_req_valid = 1'b0;

        // Four simultaneous responses leave in arbitration order, one per cycle
        for (int k = 0; k < 4; k++) set_resp(k, 10 + k, 100 + k);
        bus.pe_resp_valid = 4'hF;
        bus.up_resp_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("merge_pe_resp_ready", bus.pe_resp_ready, 64'(1 << k));
            tick();
            bus.pe_resp_valid[k] = 1'b0;
            #1;
            chk("merge_up_resp_valid", bus.up_resp_valid, 1);
            chk("merge_up_resp_tag", bus.up_resp_tag, 64'(10 + k));
            chk("merge_up_resp_len", bus.up_resp_match_len, 64'(100 + k));
        end
        tick();
        chk("merge_drained", bus.up_resp_valid, 0);

        // Backpressure holds tag 7 stable and blocks further captures
        bus.up_resp_ready = 1'b0;
        set_resp(0, 7, 32);
        set_resp(2, 9, 5);
        bus.pe_resp_valid = 4'b0101;
        #1;
        chk("hold_first_grant", bus.pe_resp_ready, 4'b0001);
        tick();
        bus.pe_resp_valid[0] = 1'b0;
        #1;
        for (int j = 0; j < 5; j++) begin
            chk("hold_valid", bus.up_resp_valid, 1);
            chk("hold_tag", bus.up_resp_tag, 7);
            chk("hold_len", bus.up_resp_match_len, 32);
            chk("hold_pe_resp_ready", bus.pe_resp_ready, 0);
            tick();
        end
        bus.up_resp_ready = 1'b1;
        #1;
        chk("release_pe_resp_ready", bus.pe_resp_ready, 4'b0100);
        tick();
        bus.pe_resp_valid[2] = 1'b0;
        bus.up_resp_ready    = 1'b0;
        #1;
        chk("release_next_valid", bus.up_resp_valid, 1);
        chk("release_next_tag", bus.up_resp_tag, 9);
        chk("release_next_len", bus.up_resp_match_len, 5);

        // Request and drain together at outstanding=3: count must stay at 3
        bus.up_req_valid  = 1'b1;
        bus.up_resp_ready = 1'b1;
        #1;
        chk("both_pe_req_valid", bus.pe_req_valid, 4'b0001);
        tick();
        bus.up_req_valid = 1'b0;
        #1;
        chk("both_up_resp_valid", bus.up_resp_valid, 0);
        chk("both_idle", idle, 0);
        for (int n = 0; n < 3; n++) begin
            set_resp(3, 20 + n, n);
            bus.pe_resp_valid = 4'b1000;
            #1;
            chk("three_pe_resp_ready", bus.pe_resp_ready, 4'b1000);
            tick();
            bus.pe_resp_valid = '0;
            #1;
            chk("three_up_resp_valid", bus.up_resp_valid, 1);
            chk("three_up_resp_tag", bus.up_resp_tag, 64'(20 + n));
            chk("three_idle_busy", idle, 0);
        end
        tick();
        chk("three_drained", bus.up_resp_valid, 0);
        chk("three_idle", idle, 1);
        bus.up_resp_ready = 1'b0;

        // Round-robin skips non-ready PEs; req_ptr walks 1 -> 0 -> 3 -> 0 -> 1 -> 2
        bus.up_req_valid = 1'b1;
        bus.pe_req_ready = 4'b1000;
        #1;
        chk("rr_only_pe3", bus.pe_req_valid, 4'b1000);
        tick();
        bus.pe_req_ready = 4'b0100;
        #1;
        chk("rr_ptr0_pe2", bus.pe_req_valid, 4'b0100);
        tick();
        bus.pe_req_ready = 4'hF;
        #1;
        chk("rr_ptr_now_3", bus.pe_req_valid, 4'b1000);
        tick();
        chk("rr_wrap_pe0", bus.pe_req_valid, 4'b0001);
        tick();
        chk("rr_next_pe1", bus.pe_req_valid, 4'b0010);
        tick();
        bus.up_req_valid = 1'b0;

        // Five outstanding plus a held response, then reset mid-operation
        set_resp(1, 8'h33, 3);
        bus.pe_resp_valid = 4'b0010;
        #1;
        chk("pre_rst_grant", bus.pe_resp_ready, 4'b0010);
        tick();
        bus.pe_resp_valid = '0;
        #1;
        chk("pre_rst_valid", bus.up_resp_valid, 1);
        chk("pre_rst_tag", bus.up_resp_tag, 8'h33);
        chk("pre_rst_idle", idle, 0);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_up_resp_valid", bus.up_resp_valid, 0);
        chk("mid_rst_idle", idle, 1);
        rst_n = 1'b1;
        #1;
        chk("post_rst_idle", idle, 1);
        bus.pe_resp_valid = 4'b0011;
        #1;
        chk("post_rst_resp_ptr", bus.pe_resp_ready, 4'b0001);
        bus.pe_resp_valid = '0;

        // Counter and req_ptr cleared: eight fresh requests from PE0 before full
        bus.up_req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("post_rst_pe_req_valid", bus.pe_req_valid, 64'(1 << (i % 4)));
            chk("post_rst_up_req_ready", bus.up_req_ready, 1);
            tick();
        end
        chk("post_rst_full", bus.up_req_ready, 0);
        bus.up_req_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
